// File: rtl/fc_pkg.sv
// Shared types, constants and the 32-bit saturation helper for the FC tile scheduler.
package fc_pkg;

  localparam int unsigned ACC_W = 32;
  localparam logic signed [ACC_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [ACC_W-1:0] SAT_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fc_state_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } fc_tag_t;

  // Overflow is detected when the two top bits of the 33-bit sum disagree.
  function automatic logic signed [ACC_W-1:0] sat32(input logic signed [ACC_W:0] v);
    if (v[ACC_W] != v[ACC_W-1]) begin
      return v[ACC_W] ? SAT_MIN : SAT_MAX;
    end
    return v[ACC_W-1:0];
  endfunction

endpackage

// File: rtl/fc_result_fifo.sv
// Synchronous result FIFO with occupancy count; head reads as zero when empty.
module fc_result_fifo
  import fc_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fc_tile_scheduler.sv
// Fully-connected layer sequencer: issues neuron x tile reads to a PE chain and buffers results.
// Optional FC_RELU_EN: clamp each final neuron result at zero before it enters the FIFO.
module fc_tile_scheduler
  import fc_pkg::*;
#(
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned ARRAY_LAT  = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       cfg_in_len,
  input  logic [ADDR_W-1:0]       cfg_out_len,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       ifm_addr,
  output logic [ADDR_W-1:0]       w_addr,
  output logic [NUM_PE-1:0]       lane_mask,
  input  logic signed [ACC_W-1:0] arr_sum,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  input  logic                    out_ready
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EW    = ADDR_W + $clog2(NUM_PE) + 1;

  fc_state_t               state_q, state_d;
  logic [ADDR_W-1:0]       in_len_q, in_len_d, out_len_q, out_len_d;
  logic [ADDR_W-1:0]       num_tiles_q, num_tiles_d, tile_q, tile_d, neuron_q, neuron_d;
  logic [ADDR_W-1:0]       wcnt_q, wcnt_d, ifm_addr_q, ifm_addr_d, w_addr_q, w_addr_d;
  logic [NUM_PE-1:0]       lane_mask_q, lane_mask_d, tile_mask;
  fc_tag_t                 iss_tag_q, iss_tag_d, tag_out;
  fc_tag_t                 tag_pipe_q [ARRAY_LAT];
  logic signed [ACC_W-1:0] acc_q, acc_d, result, push_data, fifo_data;
  logic signed [ACC_W:0]   sum33;
  logic [CNT_W-1:0]        inflight_q, inflight_d, fifo_count;
  logic                    issue, first_issue, credit_ok, last_tile, last_neuron;
  logic                    pipe_empty, push, pop, fifo_valid;

  assign tag_out = tag_pipe_q[ARRAY_LAT-1];

  always_comb begin
    tile_mask = '0;
    for (int unsigned k = 0; k < NUM_PE; k++) begin
      tile_mask[k] = (EW'(tile_q) * EW'(NUM_PE) + EW'(k)) < EW'(in_len_q);
    end
  end

  always_comb begin
    pipe_empty = !iss_tag_q.valid;
    for (int unsigned i = 0; i < ARRAY_LAT; i++) begin
      if (tag_pipe_q[i].valid) pipe_empty = 1'b0;
    end
  end

  // Accumulate tile sums; saturation only guards the running sum, never the tile value itself.
  always_comb begin
    sum33  = {acc_q[ACC_W-1], acc_q} + {arr_sum[ACC_W-1], arr_sum};
    result = tag_out.first ? arr_sum : sat32(sum33);
    acc_d  = tag_out.valid ? result : acc_q;
    push   = tag_out.valid && tag_out.last;
  end

`ifdef FC_RELU_EN
  assign push_data = result[ACC_W-1] ? '0 : result;
`else
  assign push_data = result;
`endif

  assign pop       = fifo_valid && out_ready;
  assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < int'(FIFO_DEPTH);
  assign last_tile   = (tile_q == num_tiles_q - ADDR_W'(1));
  assign last_neuron = (neuron_q == out_len_q - ADDR_W'(1));

  always_comb begin
    state_d     = state_q;
    in_len_d    = in_len_q;
    out_len_d   = out_len_q;
    num_tiles_d = num_tiles_q;
    tile_d      = tile_q;
    neuron_d    = neuron_q;
    wcnt_d      = wcnt_q;
    ifm_addr_d  = ifm_addr_q;
    w_addr_d    = w_addr_q;
    lane_mask_d = '0;
    iss_tag_d   = '0;
    issue       = 1'b0;
    first_issue = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          in_len_d    = cfg_in_len;
          out_len_d   = cfg_out_len;
          num_tiles_d = cfg_in_len / ADDR_W'(NUM_PE)
                      + ADDR_W'(|(cfg_in_len % ADDR_W'(NUM_PE)));
          tile_d      = '0;
          neuron_d    = '0;
          wcnt_d      = '0;
          state_d     = ((cfg_in_len == '0) || (cfg_out_len == '0)) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        // Credit is only checked on a neuron's first tile; its remaining tiles never stall.
        issue       = (tile_q != '0) || credit_ok;
        first_issue = issue && (tile_q == '0);
        if (issue) begin
          iss_tag_d   = '{valid: 1'b1, first: (tile_q == '0), last: last_tile};
          ifm_addr_d  = tile_q;
          w_addr_d    = wcnt_q;
          lane_mask_d = tile_mask;
          wcnt_d      = wcnt_q + ADDR_W'(1);
          if (last_tile) begin
            tile_d = '0;
            if (last_neuron) state_d = DRAIN;
            else             neuron_d = neuron_q + ADDR_W'(1);
          end else begin
            tile_d = tile_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (pipe_empty && (inflight_q == '0) &&
            ((fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    inflight_d = inflight_q + CNT_W'(first_issue) - CNT_W'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_len_q    <= '0;
      out_len_q   <= '0;
      num_tiles_q <= '0;
      tile_q      <= '0;
      neuron_q    <= '0;
      wcnt_q      <= '0;
      ifm_addr_q  <= '0;
      w_addr_q    <= '0;
      lane_mask_q <= '0;
      iss_tag_q   <= '0;
      acc_q       <= '0;
      inflight_q  <= '0;
      for (int unsigned i = 0; i < ARRAY_LAT; i++) tag_pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      in_len_q    <= in_len_d;
      out_len_q   <= out_len_d;
      num_tiles_q <= num_tiles_d;
      tile_q      <= tile_d;
      neuron_q    <= neuron_d;
      wcnt_q      <= wcnt_d;
      ifm_addr_q  <= ifm_addr_d;
      w_addr_q    <= w_addr_d;
      lane_mask_q <= lane_mask_d;
      iss_tag_q   <= iss_tag_d;
      acc_q       <= acc_d;
      inflight_q  <= inflight_d;
      tag_pipe_q[0] <= iss_tag_q;
      for (int unsigned i = 1; i < ARRAY_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
    end
  end

  fc_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ACC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (fifo_data),
    .count_o (fifo_count)
  );

  assign busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign rd_en     = iss_tag_q.valid;
  assign ifm_addr  = ifm_addr_q;
  assign w_addr    = w_addr_q;
  assign lane_mask = lane_mask_q;
  assign out_valid = fifo_valid;
  assign out_data  = fifo_data;

endmodule

// File: tb/tb_fc_tile_scheduler.sv
// Directed bench for fc_tile_scheduler; the PE chain is modelled as a delayed masked dot product.
module tb_fc_tile_scheduler;

  localparam int NP = 4;
  localparam int LAT = 6;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst, start, out_ready;
  logic [AW-1:0]     cfg_in_len, cfg_out_len;
  logic              busy, done, rd_en, out_valid;
  logic [AW-1:0]     ifm_addr, w_addr;
  logic [NP-1:0]     lane_mask;
  logic signed [31:0] arr_sum, out_data;

  typedef struct { int ia; int wa; int m; int cy; } iss_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   ifm [64];
  int   wgt [64];
  int   pend [int];
  bit   force_mode = 0;
  int   force_q [$];
  int   got_q [$];
  iss_t iss_q [$];

  always #5 clk = ~clk;

  fc_tile_scheduler #(.NUM_PE(NP), .ARRAY_LAT(LAT), .FIFO_DEPTH(4), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
    .busy(busy), .done(done), .rd_en(rd_en), .ifm_addr(ifm_addr), .w_addr(w_addr),
    .lane_mask(lane_mask), .arr_sum(arr_sum), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // PE chain model plus output/issue monitors, all sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      pend.delete();
      arr_sum = 0;
    end else begin
      arr_sum = pend.exists(cyc) ? pend[cyc] : 0;
      if (rd_en) begin
        int s;
        s = 0;
        if (force_mode) begin
          if (force_q.size() > 0) s = force_q.pop_front();
        end else begin
          for (int k = 0; k < NP; k++) begin
            int ii, wi;
            ii = int'(ifm_addr) * NP + k;
            wi = int'(w_addr) * NP + k;
            if (lane_mask[k] && ii < 64 && wi < 64) s += ifm[ii] * wgt[wi];
          end
        end
        pend[cyc + LAT] = s;
        iss_q.push_back('{ia: int'(ifm_addr), wa: int'(w_addr), m: int'(lane_mask), cy: cyc});
      end
      if (out_valid && out_ready) got_q.push_back(int'(out_data));
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int exp_res(input int v);
`ifdef FC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input int il, input int ol);
    cfg_in_len  = AW'(il);
    cfg_out_len = AW'(ol);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c, d0;
    c  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && c < budget) begin
      tick(1);
      c++;
    end
    if (done_cnt == d0) chk({tag, "_done_timeout"}, 0, 1);
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_done"}, done, 0);
    chk({p, "_rd_en"}, rd_en, 0);
    chk({p, "_ifm_addr"}, ifm_addr, 0);
    chk({p, "_w_addr"}, w_addr, 0);
    chk({p, "_lane_mask"}, lane_mask, 0);
    chk({p, "_out_valid"}, out_valid, 0);
    chk({p, "_out_data"}, out_data, 0);
  endtask

  task automatic check_results(input string p, input int exp [$]);
    chk({p, "_nres"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk($sformatf("%s_res%0d", p, i), got_q[i], exp_res(exp[i]));
  endtask

  task automatic clear_logs();
    got_q.delete();
    iss_q.delete();
  endtask

  task automatic load_t1();
    for (int i = 0; i < 64; i++) begin ifm[i] = 0; wgt[i] = 0; end
    ifm[0] = 1; ifm[1] = 2; ifm[2] = 3; ifm[3] = 4;
    wgt[0] = 1; wgt[1] = 1; wgt[2] = 1; wgt[3] = 1;
    wgt[4] = 2;
    wgt[11] = 5;
  endtask

  task automatic run_t1(input string p);
    int d0;
    d0 = done_cnt;
    clear_logs();
    launch(4, 3);
    chk({p, "_busy"}, busy, 1);
    wait_done(p, 100);
    tick(2);
    chk({p, "_done_once"}, done_cnt - d0, 1);
    chk({p, "_idle"}, busy, 0);
    chk({p, "_nissue"}, iss_q.size(), 3);
    for (int i = 0; i < iss_q.size(); i++) begin
      chk($sformatf("%s_waddr%0d", p, i), iss_q[i].wa, i);
      chk($sformatf("%s_mask%0d", p, i), iss_q[i].m, 15);
    end
    if (iss_q.size() == 3) chk({p, "_b2b"}, iss_q[2].cy - iss_q[0].cy, 2);
    check_results(p, '{10, 2, 20});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; cfg_in_len = '0; cfg_out_len = '0;
    tick(3);
    check_reset_vals("rst");
    rst = 1'b0;
    tick(1);

    // 1: one tile per neuron, back-to-back issue.
    load_t1();
    run_t1("t1");

    // 2: partial last tile; a second start while busy must be ignored.
    for (int i = 0; i < 64; i++) begin ifm[i] = 0; wgt[i] = 0; end
    for (int i = 0; i < 6; i++) ifm[i] = i + 1;
    ifm[6] = 100; ifm[7] = 100;
    for (int i = 0; i < 6; i++) wgt[i] = 1;
    wgt[6] = 9; wgt[7] = 9;
    wgt[8] = 2; wgt[13] = -1; wgt[14] = 7; wgt[15] = 7;
    clear_logs();
    launch(6, 2);
    tick(1);
    cfg_in_len = 16'd4; cfg_out_len = 16'd5; start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done("t2", 100);
    tick(2);
    chk("t2_nissue", iss_q.size(), 4);
    for (int i = 0; i < iss_q.size() && i < 4; i++) begin
      chk($sformatf("t2_waddr%0d", i), iss_q[i].wa, i);
      chk($sformatf("t2_iaddr%0d", i), iss_q[i].ia, i % 2);
      chk($sformatf("t2_mask%0d", i), iss_q[i].m, (i % 2 == 0) ? 15 : 3);
    end
    check_results("t2", '{21, -4});

    // 3: saturation of the running sum in both directions.
    force_mode = 1;
    force_q = '{2147483647, 5, int'(32'h8000_0000), -1};
    clear_logs();
    launch(8, 2);
    wait_done("t3", 100);
    tick(2);
    force_mode = 0;
    check_results("t3", '{2147483647, int'(32'h8000_0000)});

    // 4: consumer stalled, credits limit issue to FIFO depth.
    for (int i = 0; i < 64; i++) begin ifm[i] = 0; wgt[i] = 0; end
    for (int i = 0; i < 4; i++) ifm[i] = i + 1;
    for (int n = 0; n < 8; n++) wgt[4 * n] = n + 1;
    out_ready = 1'b0;
    clear_logs();
    launch(4, 8);
    tick(30);
    chk("t4_stall_issues", iss_q.size(), 4);
    chk("t4_stall_rd_en", rd_en, 0);
    chk("t4_stall_valid", out_valid, 1);
    chk("t4_hold_a", out_data, exp_res(1));
    tick(3);
    chk("t4_hold_b", out_data, exp_res(1));
    out_ready = 1'b1;
    wait_done("t4", 200);
    tick(2);
    chk("t4_nissue", iss_q.size(), 8);
    check_results("t4", '{1, 2, 3, 4, 5, 6, 7, 8});

    // 5: reset mid-layer, then a clean rerun.
    load_t1();
    clear_logs();
    launch(4, 3);
    tick(2);
    rst = 1'b1;
    tick(1);
    check_reset_vals("t5");
    rst = 1'b0;
    tick(1);
    run_t1("t5run");

    // 6: zero-length layer and sign handling of the final result.
    clear_logs();
    launch(0, 5);
    chk("t6_zero_done", done, 1);
    tick(3);
    chk("t6_zero_noread", iss_q.size(), 0);
    chk("t6_zero_idle", done, 0);
    for (int i = 0; i < 64; i++) begin ifm[i] = 0; wgt[i] = 0; end
    ifm[0] = 1;
    wgt[0] = -10; wgt[4] = 10;
    clear_logs();
    launch(4, 2);
    wait_done("t6", 100);
    tick(2);
    check_results("t6", '{-10, 10});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
